// File: rtl/mips_boot_mem.sv
// rtl/mips_boot_mem.sv - unified MIPS instruction/data memory with clear/load boot sequencer
// Holds the core in reset until a program image has been streamed in after an optional zero-fill.
module mips_boot_mem #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int CLEAR_ON_BOOT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  boot_start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  cpu_rst_n,
    output logic                  booted,
    output logic                  load_overflow,
    output logic [ADDR_WIDTH:0]   load_count,
    input  logic [31:0]           cpu_addr,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam state_t ST_BOOT = (CLEAR_ON_BOOT != 0) ? ST_CLEAR : ST_LOAD;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_ptr;
    logic [ADDR_WIDTH:0]     r_load_count;
    logic                    r_load_overflow;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_xfer;
    logic                    w_load_at_end;
    logic                    w_reboot;
    logic [ADDR_WIDTH-1:0]   w_cpu_idx;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;
    logic                    w_unused;

    // Byte offset and high address bits are dropped so addresses alias modulo DEPTH words.
    assign w_cpu_idx     = cpu_addr[ADDR_WIDTH+1:2];
    assign w_unused      = &{1'b0, cpu_addr[31:ADDR_WIDTH+2], cpu_addr[1:0]};
    assign w_xfer        = load_valid && load_ready;
    assign w_load_at_end = (r_load_count == (ADDR_WIDTH+1)'(DEPTH - 1));
    assign w_reboot      = (r_state == ST_RUN) && boot_start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_xfer && (load_last || w_load_at_end)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (boot_start) begin
                    w_state_nxt = ST_BOOT;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        booted     = 1'b0;
        cpu_rst_n  = 1'b0;
        case (r_state)
            ST_LOAD: load_ready = 1'b1;
            ST_RUN: begin
                booted    = 1'b1;
                cpu_rst_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_ptr       <= '0;
            r_load_count    <= '0;
            r_load_overflow <= 1'b0;
        end else if (w_reboot) begin
            r_clr_ptr       <= '0;
            r_load_count    <= '0;
            r_load_overflow <= 1'b0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
            end
            if (w_xfer && (r_load_count != (ADDR_WIDTH+1)'(DEPTH))) begin
                r_load_count <= r_load_count + (ADDR_WIDTH+1)'(1);
            end
            if (w_xfer && !load_last && w_load_at_end) begin
                r_load_overflow <= 1'b1;
            end
        end
    end

    // One write port shared by clear, loader and core; reset never disturbs the contents.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (rst_n) begin
            case (r_state)
                ST_CLEAR: begin
                    w_mem_we   = 1'b1;
                    w_mem_addr = r_clr_ptr;
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = r_load_count[ADDR_WIDTH-1:0];
                        w_mem_wdata = load_data;
                    end
                end
                ST_RUN: begin
                    if (cpu_we) begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = w_cpu_idx;
                        w_mem_wdata = cpu_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign cpu_rdata     = r_mem[w_cpu_idx];
    assign load_overflow = r_load_overflow;
    assign load_count    = r_load_count;

endmodule

// File: tb/tb_mips_boot_mem.sv
// tb/tb_mips_boot_mem.sv - scoreboard bench for mips_boot_mem boot, load, aliasing and reboot
module tb_mips_boot_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        cpu_rst_n;
    logic        booted;
    logic        load_overflow;
    logic [8:0]  load_count;
    logic [31:0] cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;

    mips_boot_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CLEAR_ON_BOOT(1)) dut (
        .clk(clk), .rst_n(rst_n), .boot_start(boot_start),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_last(load_last), .cpu_rst_n(cpu_rst_n), .booted(booted),
        .load_overflow(load_overflow), .load_count(load_count),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_item_t;

    rd_item_t rd_q[$];
    logic     rd_vld = 1'b0;
    int       n_cmp = 0;
    int       n_err = 0;

    // Monitor: every cycle the bench presents a read, the oldest expectation is retired.
    always @(negedge clk) begin
        if (rd_vld) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_underflow: read presented with no expectation queued, rdata=%08h", cpu_rdata);
            end else begin
                rd_item_t it;
                it = rd_q.pop_front();
                if (cpu_rdata !== it.exp) begin
                    n_err++;
                    $display("FAIL %s: got %08h expected %08h", it.name, cpu_rdata, it.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        rd_item_t it;
        it.name = nm;
        it.exp  = exp;
        rd_q.push_back(it);
        cpu_addr = a;
        rd_vld   = 1'b1;
        tick();
        rd_vld   = 1'b0;
    endtask

    task automatic wait_ready(input string nm, input int exp_cycles);
        int n;
        bit low_ok;
        n = 0;
        low_ok = 1'b1;
        while (!load_ready && n < 2000) begin
            if (cpu_rst_n !== 1'b0) low_ok = 1'b0;
            tick();
            n++;
        end
        chk({nm, "_clear_cycles"}, n, exp_cycles);
        chk({nm, "_cpu_rst_low_in_clear"}, {31'd0, low_ok}, 32'd1);
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int g;
        g = 0;
        load_data  = d;
        load_last  = last;
        load_valid = 1'b1;
        while (!load_ready && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: load_ready=%0b expected 1", load_ready);
        end
        tick();
    endtask

    task automatic idle_load();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic do_reboot(input string nm);
        boot_start = 1'b1;
        tick();
        boot_start = 1'b0;
        chk({nm, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
        chk({nm, "_booted"}, {31'd0, booted}, 32'd0);
        chk({nm, "_load_count"}, {23'd0, load_count}, 32'd0);
        chk({nm, "_overflow"}, {31'd0, load_overflow}, 32'd0);
    endtask

    logic [31:0] prog [4];
    logic [31:0] rnd_words [8];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        prog[0] = 32'h2003_0080;
        prog[1] = 32'h2004_000F;
        prog[2] = 32'hAC04_0000;
        prog[3] = 32'h8C05_0000;
        for (int i = 0; i < 8; i++) rnd_words[i] = 32'hA500_0000 + 32'(i * 17);

        // Reset state and first clear.
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_booted", {31'd0, booted}, 32'd0);
        chk("rst_load_count", {23'd0, load_count}, 32'd0);
        chk("rst_overflow", {31'd0, load_overflow}, 32'd0);
        wait_ready("boot0", 256);
        for (int i = 0; i < 256; i++) rd(32'(i * 4), 32'h0, "boot0_zero");

        // Four-word program, back to back.
        for (int i = 0; i < 4; i++) send(prog[i], i == 3);
        chk("prog_booted", {31'd0, booted}, 32'd1);
        chk("prog_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        chk("prog_load_ready", {31'd0, load_ready}, 32'd0);
        chk("prog_load_count", {23'd0, load_count}, 32'd4);
        chk("prog_overflow", {31'd0, load_overflow}, 32'd0);
        idle_load();
        for (int i = 0; i < 4; i++) rd(32'(i * 4), prog[i], "prog_word");

        // Aliased write; same-cycle read must still see the old word 1.
        cpu_addr  = 32'h0000_0404;
        cpu_wdata = 32'h1234_5678;
        cpu_we    = 1'b1;
        begin
            rd_item_t it;
            it.name = "alias_old_value";
            it.exp  = prog[1];
            rd_q.push_back(it);
        end
        rd_vld = 1'b1;
        tick();
        rd_vld = 1'b0;
        cpu_we = 1'b0;
        rd(32'h0000_0004, 32'h1234_5678, "alias_rd_004");
        rd(32'h0000_0007, 32'h1234_5678, "alias_rd_007");
        rd(32'h0000_0404, 32'h1234_5678, "alias_rd_404");
        rd(32'h0000_0008, prog[2], "alias_neighbour");

        // Reboot with a write in the same cycle, then a gappy load.
        cpu_addr  = 32'h0000_0010;
        cpu_wdata = 32'h5555_AAAA;
        cpu_we    = 1'b1;
        do_reboot("reboot1");
        cpu_we = 1'b0;
        rd(32'h0000_0010, 32'h5555_AAAA, "reboot_write_kept");
        wait_ready("reboot1", 255);
        cpu_addr  = 32'h0000_0320;
        cpu_wdata = 32'h0BAD_0BAD;
        cpu_we    = 1'b1;
        tick();
        cpu_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            while ($urandom_range(0, 1) == 1) begin
                load_valid = 1'b0;
                load_data  = 32'hFFFF_FFFF;
                tick();
            end
            send(rnd_words[i], i == 7);
        end
        idle_load();
        chk("gappy_load_count", {23'd0, load_count}, 32'd8);
        chk("gappy_booted", {31'd0, booted}, 32'd1);
        for (int i = 0; i < 8; i++) rd(32'(i * 4), rnd_words[i], "gappy_word");
        rd(32'h0000_0020, 32'h0, "gappy_no_extra");
        rd(32'h0000_0320, 32'h0, "we_in_load_ignored");

        // Overflow: full image with no last marker.
        do_reboot("reboot2");
        wait_ready("reboot2", 256);
        for (int i = 0; i < 256; i++) begin
            send(32'hDEAD_BEEF, 1'b0);
            if (i == 254) chk("ovf_not_yet", {31'd0, booted}, 32'd0);
        end
        idle_load();
        chk("ovf_flag", {31'd0, load_overflow}, 32'd1);
        chk("ovf_booted", {31'd0, booted}, 32'd1);
        chk("ovf_load_ready", {31'd0, load_ready}, 32'd0);
        chk("ovf_load_count", {23'd0, load_count}, 32'd256);
        load_valid = 1'b1;
        load_data  = 32'h7777_7777;
        tick();
        load_valid = 1'b0;
        chk("ovf_count_saturated", {23'd0, load_count}, 32'd256);
        rd(32'h0000_0000, 32'hDEAD_BEEF, "ovf_word0");
        rd(32'h0000_03FC, 32'hDEAD_BEEF, "ovf_word255");

        // Reboot over the DEADBEEF-filled array must zero everything.
        do_reboot("reboot3");
        wait_ready("reboot3", 256);
        for (int i = 0; i < 256; i++) rd(32'(i * 4), 32'h0, "reboot3_zero");

        // Reset mid-LOAD restarts the clear from word 0.
        for (int i = 0; i < 3; i++) send(32'hC0DE_0000 + 32'(i), 1'b0);
        idle_load();
        chk("midload_count", {23'd0, load_count}, 32'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midload_rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("midload_rst_ready", {31'd0, load_ready}, 32'd0);
        chk("midload_rst_count", {23'd0, load_count}, 32'd0);
        wait_ready("midload", 256);
        rd(32'h0000_0000, 32'h0, "midload_word0_cleared");
        rd(32'h0000_0008, 32'h0, "midload_word2_cleared");
        send(32'hFEED_F00D, 1'b1);
        idle_load();
        chk("final_booted", {31'd0, booted}, 32'd1);
        rd(32'h0000_0000, 32'hFEED_F00D, "final_word0");

        chk("scoreboard_drained", rd_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_boot_mem.md
# mips_boot_mem

Parametrised unified instruction/data memory for the multi-cycle MIPS core, with a built-in boot sequencer. After reset it zero-fills the whole array, accepts a program image word-by-word over a valid/ready stream, and holds the CPU in reset until the image is loaded. Its CPU port then serves as the core's single memory. It replaces the hierarchical clearing and poking of memory and register contents from the bench, and is instantiated inside `cpu_top` next to the datapath.

## Interface
- DATA_WIDTH, 32: memory word width in bits.
- ADDR_WIDTH, 8: word-address width; DEPTH = 2**ADDR_WIDTH words.
- CLEAR_ON_BOOT, 1: 1 = zero-fill the array before loading; 0 = skip the clear phase.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset. Synchronous, active-low.
- boot_start  in  1  one-cycle request to re-run the boot sequence; honoured only in RUN.
- load_valid  in  1  loader word valid.
- load_ready  out  1  block accepts a loader word this cycle.
- load_data  in  DATA_WIDTH  program word.
- load_last  in  1  marks the final word of the image.
- cpu_rst_n  out  1  active-low reset to the CPU core; high only in RUN.
- booted  out  1  image loaded; equals the RUN state.
- load_overflow  out  1  image filled DEPTH words without load_last; sticky until the next boot.
- load_count  out  ADDR_WIDTH+1  number of words accepted in the current boot.
- cpu_addr  in  32  byte address from the core.
- cpu_we  in  1  core write enable.
- cpu_wdata  in  DATA_WIDTH  core write data.
- cpu_rdata  out  DATA_WIDTH  read data.

## Operation
- Storage: DEPTH x DATA_WIDTH array. Word index = cpu_addr[ADDR_WIDTH+1:2].
  - cpu_addr[1:0] and bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo DEPTH words.
- Read is combinational: cpu_rdata = mem[index] in every state.
- rst_n does not alter array contents; only the CLEAR phase zeroes them.
- FSM states: CLEAR, LOAD, RUN.
  - CLEAR: clr_ptr counts 0..DEPTH-1 and writes 0 to mem[clr_ptr] each cycle. After writing DEPTH-1, go to LOAD.
  - LOAD: load_ready=1. On load_valid&&load_ready, write mem[load_count]=load_data and increment load_count.
    - If load_last is set, go to RUN.
    - If the word just written was at DEPTH-1 and load_last is clear, set load_overflow and go to RUN.
  - RUN: cpu_rst_n=1, booted=1, load_ready=0. If cpu_we, write mem[index]=cpu_wdata.
    - boot_start in RUN clears load_count and load_overflow and goes to CLEAR, or to LOAD when CLEAR_ON_BOOT=0.
- cpu_we is ignored outside RUN.
- boot_start is ignored outside RUN.
- Loader words offered outside LOAD are not accepted, because load_ready=0.

## Timing
- Reset values (cycle after rst_n sampled low):
  - state = CLEAR, or LOAD when CLEAR_ON_BOOT=0.
  - clr_ptr=0, load_count=0, load_overflow=0, booted=0, cpu_rst_n=0.
  - load_ready=0, or 1 when CLEAR_ON_BOOT=0.
- Reset mid-CLEAR, mid-LOAD or in RUN restarts the sequence from the reset state. A partial clear or load is not resumed.
- Clear latency: exactly DEPTH cycles in CLEAR. load_ready rises on the first cycle after the write to DEPTH-1.
- Handshake: transfer occurs on a rising edge with load_valid=1 and load_ready=1.
  - Producer holds data, valid and last stable until the transfer.
  - One word per cycle sustained; no bubbles are required.
- Last transfer in cycle N: in cycle N+1, state=RUN, cpu_rst_n=1, booted=1, load_ready=0.
- Write-then-read: a write at edge N is visible on cpu_rdata in the cycle after edge N. Same-cycle read returns the old value.
- boot_start sampled in RUN at edge N: cpu_rst_n=0 and booted=0 from cycle N+1.
  - A simultaneous cpu_we in that cycle is still performed, since the state is RUN at the edge.
- load_count saturates at DEPTH; it never wraps.

## Test plan
- Reset with DEPTH=256 and CLEAR_ON_BOOT=1, array pre-filled with 0xDEADBEEF -> load_ready rises after exactly 256 cycles; every word reads 0; cpu_rst_n=0 throughout.
- Stream 0x20030080, 0x2004000F, 0xAC040000, 0x8C050000 (last on the fourth) -> mem[0..3] hold those values; load_count=4; booted=1 and cpu_rst_n=1 one cycle after the fourth transfer.
- load_valid toggled randomly during LOAD -> only handshaked words are written, in order, with no duplicates or skips.
- 256 words streamed with no load_last -> load_overflow=1; RUN entered after word 255; load_ready=0 afterwards; load_count=256.
- In RUN: write 0x12345678 to cpu_addr 0x404 with ADDR_WIDTH=8 -> aliases to word 1; reads at 0x004 and 0x007 both return 0x12345678. A cpu_we issued during LOAD leaves memory unchanged.
- boot_start in RUN, and separately rst_n low mid-LOAD -> cpu_rst_n drops next cycle; clear restarts from word 0; load_count=0; load_overflow cleared.
